// File: rtl/cacc_abuf_seq.sv
// cacc_abuf_seq: sequences MAC result beats into the per-lane CACC calc units.
// Tracks the entry position within a stripe, fetches prior partial sums from
// the assembly buffer, aligns MAC data/partials/select for the calc lanes,
// writes returned partials back, stalls on short-stripe read-after-write
// hazards, and pulses layer_done when the last final beat comes back.
module cacc_abuf_seq #(
    parameter int LANES = 8,
    parameter int AW    = 6
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rstn,
    input  logic                  mac_pvld,
    output logic                  mac_prdy,
    input  logic [22*LANES-1:0]   mac_data,
    input  logic                  mac_stripe_st,
    input  logic                  mac_stripe_end,
    input  logic                  mac_channel_end,
    input  logic                  mac_layer_end,
    output logic                  abuf_rd_en,
    output logic [AW-1:0]         abuf_rd_addr,
    input  logic [34*LANES-1:0]   abuf_rd_data,
    output logic                  calc_in_valid,
    output logic                  calc_in_sel,
    output logic [22*LANES-1:0]   calc_in_data,
    output logic [34*LANES-1:0]   calc_in_op,
    output logic                  calc_in_op_valid,
    input  logic                  calc_out_partial_valid,
    input  logic [34*LANES-1:0]   calc_out_partial_data,
    input  logic                  calc_out_final_valid,
    output logic                  abuf_wr_en,
    output logic [AW-1:0]         abuf_wr_addr,
    output logic [34*LANES-1:0]   abuf_wr_data,
    output logic                  layer_done
);

    localparam int DATA_W = 22;
    localparam int ACC_W  = 34;

    logic                     accept;
    logic                     stall;
    logic                     hit_p1;
    logic                     hit_p2;
    logic                     hit_p3;
    logic [AW-1:0]            cnt;

    // Stage 1: beat captured on accept, presented to the calc lanes.
    logic                     vld_p1;
    logic                     sel_p1;
    logic                     opv_p1;
    logic [LANES*DATA_W-1:0]  data_p1;
    logic [AW-1:0]            addr_p1;
    logic                     wb_p1;
    logic                     lend_p1;

    // Stage 2/3: tags riding alongside the calc lanes' two internal registers.
    logic                     vld_p2;
    logic [AW-1:0]            addr_p2;
    logic                     wb_p2;
    logic                     lend_p2;
    logic                     vld_p3;
    logic [AW-1:0]            addr_p3;
    logic                     wb_p3;
    logic                     lend_p3;

    // A stage holding a pending write-back to the entry we are about to read
    // blocks the read; stage 3 is included because its write lands this cycle
    // and a same-cycle read would still see the old contents.
    assign hit_p1 = vld_p1 & wb_p1 & (addr_p1 == cnt);
    assign hit_p2 = vld_p2 & wb_p2 & (addr_p2 == cnt);
    assign hit_p3 = vld_p3 & wb_p3 & (addr_p3 == cnt);

    // Stripe-start beats never read abuf, so they never stall.
    assign stall    = mac_pvld & ~mac_stripe_st & (hit_p1 | hit_p2 | hit_p3);
    assign mac_prdy = ~stall;
    assign accept   = mac_pvld & mac_prdy;

    assign abuf_rd_en   = accept & ~mac_stripe_st;
    assign abuf_rd_addr = cnt;

    assign calc_in_valid    = vld_p1;
    assign calc_in_sel      = sel_p1;
    assign calc_in_op_valid = opv_p1;
    assign calc_in_data     = data_p1;
    // abuf read data returns exactly when stage 1 is presented, so no register.
    assign calc_in_op       = abuf_rd_data;

    // Final beats return on calc_out_final_valid only, so they never write.
    assign abuf_wr_en   = calc_out_partial_valid;
    assign abuf_wr_addr = addr_p3;
    assign abuf_wr_data = calc_out_partial_data;

    // Entry counter: advance per accepted beat, restart at each stripe end.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cnt <= '0;
        end else if (accept) begin
            if (mac_stripe_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Stage-1 control: valid follows accept, select/op-valid held from the last beat.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            vld_p1 <= 1'b0;
            sel_p1 <= 1'b0;
            opv_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                sel_p1 <= mac_channel_end;
                opv_p1 <= ~mac_stripe_st;
            end
        end
    end

    // Stage-1 data and tags: no reset, qualified by vld_p1.
    always_ff @(posedge nvdla_core_clk) begin
        if (accept) begin
            data_p1 <= mac_data;
            addr_p1 <= cnt;
            wb_p1   <= ~mac_channel_end;
            lend_p1 <= mac_layer_end;
        end
    end

    // Stage 2/3 valids shadow the calc lanes' pipeline.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
        end
    end

    // Stage 2/3 tags: shifted every cycle, meaningful only where valid.
    always_ff @(posedge nvdla_core_clk) begin
        addr_p2 <= addr_p1;
        wb_p2   <= wb_p1;
        lend_p2 <= lend_p1;
        addr_p3 <= addr_p2;
        wb_p3   <= wb_p2;
        lend_p3 <= lend_p2;
    end

    // Layer completion: pulse once the tagged last final beat has returned.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            layer_done <= 1'b0;
        end else begin
            layer_done <= calc_out_final_valid & vld_p3 & lend_p3;
        end
    end

`ifndef SYNTHESIS
    // Stage-3 tags must line up with whatever the calc lanes hand back.
    always @(posedge nvdla_core_clk) begin
        if (nvdla_core_rstn) begin
            assert (vld_p3 == (calc_out_partial_valid | calc_out_final_valid));
        end
    end
`endif

endmodule

// File: doc/cacc_abuf_seq.md
# cacc_abuf_seq

Sequencer between the MAC result return and the per-lane int8 accumulate/saturate/truncate calculation units in CACC. It tracks the entry position within each stripe, reads the prior partial sums from the assembly buffer (abuf), and presents MAC data, partial sums and the final/partial select to the calc lanes with correct alignment. It writes the returned 34-bit partial results back to abuf, stalls the MAC interface on read-after-write hazards in short stripes, and signals layer completion.

## Interface
Parameters:
- LANES, 8, number of calc lanes per beat
- AW, 6, abuf address width; max stripe length 2^AW entries

Ports:
- nvdla_core_clk  in  1  clock
- nvdla_core_rstn  in  1  reset, asynchronous, active-low
- mac_pvld  in  1  MAC beat valid
- mac_prdy  out  1  beat accepted when mac_pvld & mac_prdy
- mac_data  in  22*LANES  signed 22-bit MAC sums, lane i at [22i+21:22i]
- mac_stripe_st  in  1  first channel group of stripe; no prior partial exists
- mac_stripe_end  in  1  last entry of stripe
- mac_channel_end  in  1  last channel group; produce final result
- mac_layer_end  in  1  last beat of layer; valid only with mac_channel_end
- abuf_rd_en  out  1  abuf read strobe; data returns next cycle
- abuf_rd_addr  out  AW  read entry
- abuf_rd_data  in  34*LANES  read data, 1-cycle latency
- calc_in_valid  out  1  to all lanes
- calc_in_sel  out  1  1 = final, 0 = partial
- calc_in_data  out  22*LANES  MAC data
- calc_in_op  out  34*LANES  prior partial sums
- calc_in_op_valid  out  1  0 = lanes treat op as zero
- calc_out_partial_valid  in  1  lane-0 partial valid; all lanes are lockstep
- calc_out_partial_data  in  34*LANES  partial results
- calc_out_final_valid  in  1  lane-0 final valid
- abuf_wr_en, abuf_wr_addr (AW), abuf_wr_data (34*LANES)  out  abuf write port
- layer_done  out  1  one-cycle pulse when the layer's last final beat has returned

## Operation
- Accept (cycle T) = mac_pvld & mac_prdy.
- Entry counter cnt (AW bits):
  - reset 0; +1 per accept; cleared to 0 on an accept with mac_stripe_end.
  - Wraps modulo 2^AW. A longer stripe is illegal and is not checked.
- abuf_rd_en = accept & ~mac_stripe_st, combinational. abuf_rd_addr = cnt.
- Stage-1 registers, loaded on accept: mac_data, sel = channel_end, op_valid = ~stripe_st, addr = cnt, wb = ~channel_end, lend = layer_end.
- calc_in_valid = stage-1 valid.
- calc_in_op = abuf_rd_data, passed through unregistered. It is a don't-care when op_valid = 0.
- Tag pipeline: stage-1 tags {addr, wb, lend} are delayed to stage 2 (T+2) and stage 3 (T+3), matching the calc's two-register latency.
- Write-back:
  - abuf_wr_en = calc_out_partial_valid.
  - abuf_wr_addr = stage-3 addr; abuf_wr_data = calc_out_partial_data.
  - Final beats (wb = 0) are never written back.
- Hazard stall:
  - mac_prdy = 0 when mac_pvld & ~mac_stripe_st and cnt equals the addr of any valid stage 1/2/3 entry with wb = 1.
  - Otherwise mac_prdy = 1.
  - Stripe-start beats never stall.
- layer_done: registered; set one cycle after calc_out_final_valid coincides with stage-3 lend = 1.
- Tag-consistency check, simulation only: stage-3 valid must equal calc_out_partial_valid | calc_out_final_valid.

## Timing
- Reset values:
  - mac_prdy 1.
  - abuf_rd_en 0, calc_in_valid 0, calc_in_sel 0, calc_in_op_valid 0.
  - abuf_wr_en 0, layer_done 0.
  - cnt 0; all stage valids 0.
  - Data/addr registers are non-reset.
- Latency from accept at T:
  - read issued T; calc inputs T+1; abuf write T+3; layer_done T+4.
- Abuf write at cycle W is visible to a read issued at W+1 or later. A read in the same cycle returns stale data, hence the stage-3 term in the stall.
- Stripe length ≥ 4 never stalls. Shorter stripes stall until the matching write has completed.
- Reset mid-operation clears all valids and cnt. In-flight writes are dropped; abuf contents are undefined for the interrupted stripe.
- Simultaneous accept with stripe_end and a write to the same address: the write proceeds, and the counter clears.

## Test plan
- Stripe length 4, stripe_st, one beat per cycle, channel_end = 0 -> abuf_rd_en stays 0, calc_in_op_valid = 0, abuf writes to addresses 0,1,2,3 at cycles 3,4,5,6, no stall.
- Stripe length 8, channel group 2 follows immediately -> reads of address k return the group-1 result; abuf_wr_data equals the saturated sum; mac_prdy stays 1.
- Stripe length 2, two groups:
  - beats accepted at cycles 0 and 1;
  - group-2 address 0 stalls cycles 2-3 and is accepted at cycle 4;
  - address 1 is accepted at cycle 5.
- Final group with layer_end on the last beat -> calc_in_sel = 1, no abuf_wr_en for those beats, layer_done pulses once at T+4.
- AW = 2, stripe length 4 across two stripes -> cnt wraps 3 -> 0 on stripe_end; the second stripe_st stripe reads nothing.
- Reset asserted at cycle 2 of an active stripe -> all control outputs 0 and mac_prdy = 1 next cycle; the first post-reset beat uses address 0.
